apb_top: RTL and testbench

APB bridge top: an APB master and an APB slave connected by an internal APB bus. A requester starts single read/write transfers on the master side. The slave side presents each transfer to a simple peripheral through sel/valid/error handshakes and returns read data and status to the requester.

---
 rtl/apb_pkg.sv | 17 +
 rtl/apb_master.sv | 91 +++++++++
 rtl/apb_slave.sv | 49 ++++
 rtl/apb_top.sv | 78 +++++++
 tb/tb_apb_top.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/apb_pkg.sv
// Shared types and constants for the APB bridge: master FSM states and the
// word-alignment mask used by the slave-side decode.
package apb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_t;

  localparam logic [1:0] ALIGN_MASK = 2'b11;

  function automatic logic is_misaligned(input logic [1:0] addr_lsb);
    return (addr_lsb & ALIGN_MASK) != 2'b00;
  endfunction

endpackage

// File: rtl/apb_master.sv
// APB master: three-state FSM that latches a requester transfer, drives the
// internal APB bus and captures read data / error status on completion.
module apb_master
  import apb_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] addr_m,
  input  logic                  wr_en_m,
  input  logic [DATA_WIDTH-1:0] wrdata_m,
  input  logic                  start_transfer,
  output logic [DATA_WIDTH-1:0] rdata_m,
  output logic                  slverr,
  output logic                  psel,
  output logic                  penable,
  output logic                  pwrite,
  output logic [ADDR_WIDTH-1:0] paddr,
  output logic [DATA_WIDTH-1:0] pwdata,
  input  logic [DATA_WIDTH-1:0] prdata,
  input  logic                  pready,
  input  logic                  pslverr
);

  apb_state_t state;

  // psel/penable are registered alongside the state so the bus controls
  // come straight from flops and never glitch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      psel    <= 1'b0;
      penable <= 1'b0;
      pwrite  <= 1'b0;
      paddr   <= '0;
      pwdata  <= '0;
      rdata_m <= '0;
      slverr  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start_transfer) begin
            paddr   <= addr_m;
            pwrite  <= wr_en_m;
            pwdata  <= wrdata_m;
            state   <= SETUP;
            psel    <= 1'b1;
            penable <= 1'b0;
          end
        end

        SETUP: begin
          state   <= ACCESS;
          psel    <= 1'b1;
          penable <= 1'b1;
        end

        ACCESS: begin
          if (pready) begin
            slverr <= pslverr;
            if (!pwrite && !pslverr) begin
              rdata_m <= prdata;
            end
            // A request pending at completion goes straight back to SETUP.
            if (start_transfer) begin
              paddr   <= addr_m;
              pwrite  <= wr_en_m;
              pwdata  <= wrdata_m;
              state   <= SETUP;
              psel    <= 1'b1;
              penable <= 1'b0;
            end else begin
              state   <= IDLE;
              psel    <= 1'b0;
              penable <= 1'b0;
            end
          end
        end

        default: begin
          state   <= IDLE;
          psel    <= 1'b0;
          penable <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/apb_slave.sv
// APB slave: combinational mapping of the internal APB bus onto a simple
// peripheral sel/valid/error handshake, with misaligned-address rejection.
module apb_slave
  import apb_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  psel,
  input  logic                  penable,
  input  logic                  pwrite,
  input  logic [ADDR_WIDTH-1:0] paddr,
  input  logic [DATA_WIDTH-1:0] pwdata,
  output logic [DATA_WIDTH-1:0] prdata,
  output logic                  pready,
  output logic                  pslverr,
  input  logic                  valid,
  input  logic                  error,
  input  logic [DATA_WIDTH-1:0] rdata_s,
  output logic [ADDR_WIDTH-1:0] addr_s,
  output logic                  wr_en_s,
  output logic [DATA_WIDTH-1:0] wrdata_s,
  output logic                  sel
);

  logic misaligned;

  assign misaligned = is_misaligned(paddr[1:0]);

  assign addr_s   = paddr;
  assign wr_en_s  = pwrite;
  assign wrdata_s = pwdata;

  // Misaligned accesses never reach the peripheral; they complete at once
  // with an error and zero read data.
  always_comb begin
    sel     = 1'b0;
    pready  = 1'b1;
    pslverr = 1'b1;
    prdata  = '0;
    if (!misaligned) begin
      sel     = psel & penable;
      pready  = valid;
      pslverr = valid & error;
      prdata  = rdata_s;
    end
  end

endmodule

// File: rtl/apb_top.sv
// APB bridge top: requester-facing master and peripheral-facing slave joined
// by an internal APB bus.
module apb_top
  import apb_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  PCLK,
  input  logic                  PRESETn,
  input  logic [ADDR_WIDTH-1:0] addr_m,
  input  logic                  wr_en_m,
  input  logic [DATA_WIDTH-1:0] wrdata_m,
  input  logic                  start_transfer,
  output logic [DATA_WIDTH-1:0] rdata_m,
  output logic                  slverr,
  input  logic                  valid,
  input  logic                  error,
  output logic [ADDR_WIDTH-1:0] addr_s,
  input  logic [DATA_WIDTH-1:0] rdata_s,
  output logic                  wr_en_s,
  output logic [DATA_WIDTH-1:0] wrdata_s,
  output logic                  sel
);

  logic                  psel;
  logic                  penable;
  logic                  pwrite;
  logic [ADDR_WIDTH-1:0] paddr;
  logic [DATA_WIDTH-1:0] pwdata;
  logic [DATA_WIDTH-1:0] prdata;
  logic                  pready;
  logic                  pslverr;

  apb_master #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .DATA_WIDTH(DATA_WIDTH)
  ) u_master (
    .clk           (PCLK),
    .rst           (PRESETn),
    .addr_m        (addr_m),
    .wr_en_m       (wr_en_m),
    .wrdata_m      (wrdata_m),
    .start_transfer(start_transfer),
    .rdata_m       (rdata_m),
    .slverr        (slverr),
    .psel          (psel),
    .penable       (penable),
    .pwrite        (pwrite),
    .paddr         (paddr),
    .pwdata        (pwdata),
    .prdata        (prdata),
    .pready        (pready),
    .pslverr       (pslverr)
  );

  apb_slave #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .DATA_WIDTH(DATA_WIDTH)
  ) u_slave (
    .psel    (psel),
    .penable (penable),
    .pwrite  (pwrite),
    .paddr   (paddr),
    .pwdata  (pwdata),
    .prdata  (prdata),
    .pready  (pready),
    .pslverr (pslverr),
    .valid   (valid),
    .error   (error),
    .rdata_s (rdata_s),
    .addr_s  (addr_s),
    .wr_en_s (wr_en_s),
    .wrdata_s(wrdata_s),
    .sel     (sel)
  );

endmodule

// File: tb/tb_apb_top.sv
// Directed bench for apb_top: hand-computed expectations checked 1 time unit
// after each rising clock edge.
module tb_apb_top;

  logic        PCLK;
  logic        PRESETn;
  logic [31:0] addr_m;
  logic        wr_en_m;
  logic [31:0] wrdata_m;
  logic        start_transfer;
  logic [31:0] rdata_m;
  logic        slverr;
  logic        valid;
  logic        error;
  logic [31:0] addr_s;
  logic [31:0] rdata_s;
  logic        wr_en_s;
  logic [31:0] wrdata_s;
  logic        sel;

  int n_checks = 0;
  int n_errs   = 0;

  apb_top #(
    .ADDR_WIDTH(32),
    .DATA_WIDTH(32)
  ) dut (
    .PCLK          (PCLK),
    .PRESETn       (PRESETn),
    .addr_m        (addr_m),
    .wr_en_m       (wr_en_m),
    .wrdata_m      (wrdata_m),
    .start_transfer(start_transfer),
    .rdata_m       (rdata_m),
    .slverr        (slverr),
    .valid         (valid),
    .error         (error),
    .addr_s        (addr_s),
    .rdata_s       (rdata_s),
    .wr_en_s       (wr_en_s),
    .wrdata_s      (wrdata_s),
    .sel           (sel)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_errs++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge PCLK);
    #1;
  endtask

  task automatic request(input logic [31:0] a, input logic w, input logic [31:0] d);
    addr_m         = a;
    wr_en_m        = w;
    wrdata_m       = d;
    start_transfer = 1'b1;
  endtask

  initial begin
    PRESETn        = 1'b1;
    addr_m         = '0;
    wr_en_m        = 1'b0;
    wrdata_m       = '0;
    start_transfer = 1'b0;
    valid          = 1'b0;
    error          = 1'b0;
    rdata_s        = '0;

    // Reset state
    tick();
    tick();
    chk("rst_rdata_m", rdata_m, 32'h0);
    chk("rst_slverr", {31'd0, slverr}, 32'd0);
    chk("rst_sel", {31'd0, sel}, 32'd0);
    chk("rst_addr_s", addr_s, 32'h0);
    chk("rst_wr_en_s", {31'd0, wr_en_s}, 32'd0);
    chk("rst_wrdata_s", wrdata_s, 32'h0);
    PRESETn = 1'b0;
    tick();
    chk("idle_sel", {31'd0, sel}, 32'd0);

    // Aligned write, zero wait
    request(32'h4, 1'b1, 32'h12153524);
    valid = 1'b1;
    tick();
    start_transfer = 1'b0;
    chk("w0_setup_sel", {31'd0, sel}, 32'd0);
    chk("w0_setup_addr", addr_s, 32'h4);
    tick();
    chk("w0_access_sel", {31'd0, sel}, 32'd1);
    chk("w0_wr_en_s", {31'd0, wr_en_s}, 32'd1);
    chk("w0_wrdata_s", wrdata_s, 32'h12153524);
    tick();
    chk("w0_done_sel", {31'd0, sel}, 32'd0);
    chk("w0_slverr", {31'd0, slverr}, 32'd0);
    chk("w0_rdata_m", rdata_m, 32'h0);

    // Misaligned read
    request(32'hFFFFFFE5, 1'b0, 32'h0);
    rdata_s = 32'hC0895E81;
    valid   = 1'b0;
    tick();
    start_transfer = 1'b0;
    chk("mis_setup_sel", {31'd0, sel}, 32'd0);
    tick();
    chk("mis_access_sel", {31'd0, sel}, 32'd0);
    chk("mis_pending_slverr", {31'd0, slverr}, 32'd0);
    tick();
    chk("mis_slverr", {31'd0, slverr}, 32'd1);
    chk("mis_rdata_m", rdata_m, 32'h0);
    tick();
    chk("mis_idle_sel", {31'd0, sel}, 32'd0);

    // Aligned read with two wait states
    request(32'hFFFFFFE4, 1'b0, 32'h0);
    valid = 1'b0;
    tick();
    start_transfer = 1'b0;
    chk("rw_setup_sel", {31'd0, sel}, 32'd0);
    tick();
    chk("rw_sel1", {31'd0, sel}, 32'd1);
    chk("rw_addr_s", addr_s, 32'hFFFFFFE4);
    tick();
    chk("rw_sel2", {31'd0, sel}, 32'd1);
    chk("rw_hold_rdata", rdata_m, 32'h0);
    chk("rw_hold_slverr", {31'd0, slverr}, 32'd1);
    tick();
    chk("rw_sel3", {31'd0, sel}, 32'd1);
    valid = 1'b1;
    tick();
    chk("rw_done_sel", {31'd0, sel}, 32'd0);
    chk("rw_rdata_m", rdata_m, 32'hC0895E81);
    chk("rw_slverr", {31'd0, slverr}, 32'd0);

    // Peripheral error on a write, then a read with error, then clean read
    request(32'h8, 1'b1, 32'hA5A5A5A5);
    error = 1'b1;
    tick();
    start_transfer = 1'b0;
    tick();
    tick();
    chk("err_w_slverr", {31'd0, slverr}, 32'd1);
    chk("err_w_rdata_m", rdata_m, 32'hC0895E81);
    request(32'hC, 1'b0, 32'h0);
    error = 1'b0;
    rdata_s = 32'hDEADBEEF;
    tick();
    start_transfer = 1'b0;
    tick();
    tick();
    chk("clean_slverr", {31'd0, slverr}, 32'd0);
    chk("clean_rdata_m", rdata_m, 32'hDEADBEEF);
    request(32'h10, 1'b0, 32'h0);
    error   = 1'b1;
    rdata_s = 32'h11111111;
    tick();
    start_transfer = 1'b0;
    tick();
    tick();
    chk("err_r_slverr", {31'd0, slverr}, 32'd1);
    chk("err_r_rdata_m", rdata_m, 32'hDEADBEEF);
    error = 1'b0;

    // Back-to-back reads with start held
    request(32'h20, 1'b0, 32'h0);
    rdata_s = 32'h01234567;
    tick();
    addr_m = 32'h24;
    chk("b2b_setup1_sel", {31'd0, sel}, 32'd0);
    chk("b2b_setup1_addr", addr_s, 32'h20);
    tick();
    chk("b2b_access1_sel", {31'd0, sel}, 32'd1);
    chk("b2b_access1_addr", addr_s, 32'h20);
    tick();
    rdata_s = 32'h89ABCDEF;
    chk("b2b_setup2_sel", {31'd0, sel}, 32'd0);
    chk("b2b_setup2_addr", addr_s, 32'h24);
    chk("b2b_rdata1", rdata_m, 32'h01234567);
    chk("b2b_slverr1", {31'd0, slverr}, 32'd0);
    start_transfer = 1'b0;
    tick();
    chk("b2b_access2_sel", {31'd0, sel}, 32'd1);
    tick();
    chk("b2b_rdata2", rdata_m, 32'h89ABCDEF);
    chk("b2b_done_sel", {31'd0, sel}, 32'd0);
    tick();
    chk("b2b_idle_sel", {31'd0, sel}, 32'd0);

    // Reset asserted mid-ACCESS
    request(32'h30, 1'b1, 32'h55AA55AA);
    valid = 1'b0;
    tick();
    start_transfer = 1'b0;
    tick();
    chk("mr_access_sel", {31'd0, sel}, 32'd1);
    #2;
    PRESETn = 1'b1;
    #1;
    chk("mr_async_sel", {31'd0, sel}, 32'd0);
    chk("mr_rdata_m", rdata_m, 32'h0);
    chk("mr_slverr", {31'd0, slverr}, 32'd0);
    chk("mr_addr_s", addr_s, 32'h0);
    chk("mr_wrdata_s", wrdata_s, 32'h0);
    tick();
    PRESETn = 1'b0;
    valid   = 1'b1;
    tick();
    tick();
    chk("mr_stays_idle_sel", {31'd0, sel}, 32'd0);
    chk("mr_stays_idle_addr", addr_s, 32'h0);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
